ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the banked even/odd F8 RAM between two requesters: CPU data path (m0) and debug/loader DMA (m1).
- Arbitrates requests and performs one byte or 16-bit access per clock.
- Steers each access onto the even and odd bank ports, including unaligned 16-bit accesses, and returns read data one cycle after grant.
- Sits directly in front of the ram module, which subtracts the RAM base from the bank addresses itself.

Parameters:
- ADDRBITS, 10, RAM size = 1<<ADDRBITS bytes ending at 0x3fff; must match the ram instance.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = m0 always wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request; held with stable fields until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wide / m1_wide  in  1  1 = 16-bit access, 0 = byte access
- m0_addr / m1_addr  in  16  byte address
- m0_wdata / m1_wdata  in  16  write data; byte access uses [7:0]
- m0_ack / m1_ack  out  1  one-cycle grant pulse
- m0_err / m1_err  out  1  pulses with ack on a range error
- m0_rvalid / m1_rvalid  out  1  pulses one cycle after a read ack
- m0_rdata / m1_rdata  out  16  read data, valid with rvalid
- read_addr_even, write_addr_even, read_addr_odd, write_addr_odd  out  15  bank addresses, byte address >> 1
- write_data_even, write_data_odd  out  8  bank write data
- write_en_even, write_en_odd  out  1  bank write enables
- read_data_even, read_data_odd  in  8  bank read data, 1-cycle synchronous
- busy  out  1  clear sequence in progress

Behaviour:
- RAMBASE = 0x4000 - (1<<ADDRBITS).
- At most one grant per cycle. Grant, bank drive and ack are combinational in the same cycle from req and arbitration state.
- Back-to-back grants are allowed every cycle.
- Round-robin: a pointer holds the last winner. On a tie the other requester wins. Pointer resets to "m1 last", so m0 wins the first tie.
- Byte order is big-endian: byte A goes to data[15:8], byte A+1 to data[7:0].
- Even A, wide: even bank idx A>>1 carries the hi byte; odd bank idx A>>1 carries the lo byte.
- Odd A, wide: odd bank idx A>>1 carries the hi byte; even bank idx (A>>1)+1 carries the lo byte.
- Byte access uses only the bank selected by A[0]. The other bank's write_en stays 0. A byte read returns {8'h00, byte}.
- Range error: A < RAMBASE, A > 0x3fff, or wide with A = 0x3fff. On error, ack and err pulse together and no write_en asserts. An erroring read still produces rvalid next cycle with rdata = 0x0000.
- Read steering is registered: owner, A[0] and wide are captured at grant. rvalid/rdata are driven to that owner only; the other requester's rdata is 0.
- Write in cycle N followed by a read of the same address in N+1 returns the new data.
- Idle cycle: all write_en = 0; read addresses hold their last value.
- State machine: CLEAR -> RUN. CLEAR exists only with the optional feature; otherwise reset enters RUN directly.
- Reset values: ack, err, rvalid = 0; rdata = 0; write_en = 0; busy = 0 (1 with the feature); state = CLEAR (or RUN without the feature).
- Reset asserted mid-read drops the pending rvalid.
- write_en outputs are forced to 0 while rst_n is low.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Defined: after rst_n rises, a counter walks idx 0..(SIZE/2-1). Each cycle it writes 0x00 to both banks at address RAMBASE/2 + idx. busy = 1 and no acks are issued for the whole sequence, then the state moves to RUN.
- Undefined: busy is tied 0, there is no counter, and reset goes straight to RUN.

Decomposition:
- Package ram_arb_pkg holds: mem_req_t struct {we, wide, addr[15:0], wdata[15:0]}; state enum {CLEAR, RUN}; function computing bank addresses and byte lanes from addr/wide.
- Sub-module rr_arbiter2 contains the 2-way round-robin/fixed-priority grant and the pointer register.

Test Plan (ADDRBITS=10, RAMBASE=0x3c00):
- m0 wide write 0x3c00 data 0xa55a -> even/odd write_addr 0x1e00, even data 0xa5, odd data 0x5a. A subsequent wide read 0x3c00 -> rvalid next cycle with rdata 0xa55a.
- m1 wide write 0x3c01 data 0x1234 -> odd 0x1e00=0x12, even 0x1e01=0x34. Byte reads: 0x3c01 -> 0x0012; 0x3c02 -> 0x0034.
- m0 and m1 both requesting continuously -> acks alternate m0, m1, m0, m1; with FIXED_PRIO=1 only m0 is acked.
- Write 0x3bff, or wide read at 0x3fff -> ack+err, write_en stays 0, read gives rdata 0x0000.
- RAM_CLEAR_EN defined: busy high exactly 512 cycles after reset release; m0_req held during that time gets no ack; afterwards a read of 0x3e10 returns 0x0000.
- rst_n pulsed low between a read ack and its rvalid -> rvalid never pulses, all outputs return to reset values.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the even/odd banked RAM port arbiter: request bundle, FSM
// states and the helper that maps a byte address onto the two bank ports.
package ram_arb_pkg;

  localparam logic [15:0] RAM_TOP = 16'h3fff;

  typedef struct packed {
    logic        we;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic [14:0] even_idx;
    logic [14:0] odd_idx;
    logic        use_even;
    logic        use_odd;
    logic [7:0]  even_data;
    logic [7:0]  odd_data;
  } bank_map_t;

  // Big-endian: the bank holding byte A carries wdata[15:8] on a wide access.
  // An odd wide access spills its low byte into the next even bank word.
  function automatic bank_map_t bank_map(input logic [15:0] addr, input logic wide,
                                         input logic [15:0] wdata);
    bank_map_t m;
    m.odd_idx  = addr[15:1];
    m.even_idx = addr[15:1] + {14'd0, addr[0] & wide};
    m.use_even = wide | ~addr[0];
    m.use_odd  = wide | addr[0];
    if (wide) begin
      m.even_data = addr[0] ? wdata[7:0]  : wdata[15:8];
      m.odd_data  = addr[0] ? wdata[15:8] : wdata[7:0];
    end else begin
      m.even_data = wdata[7:0];
      m.odd_data  = wdata[7:0];
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin on a tie (the requester that did not win last
// goes first), or strict m0 priority when FIXED_PRIO is nonzero.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ((FIXED_PRIO != 0) || last_q) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer starts as "m1 won last" so m0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the even/odd byte-banked RAM between the CPU (m0) and DMA (m1) ports.
// Define RAM_CLEAR_EN to zero-fill the RAM after reset while busy is high.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRBITS   = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_wide,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_wide,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic [14:0] read_addr_even,
  output logic [14:0] write_addr_even,
  output logic [14:0] read_addr_odd,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd,
  output logic        busy
);

  localparam logic [15:0] RAMBASE = 16'(32'h4000 - (32'd1 << ADDRBITS));

  mem_req_t    m0_bus, m1_bus, sel;
  bank_map_t   map;
  state_t      state_q, state_d;
  logic [1:0]  gnt;
  logic        arb_en, granted, range_err, clearing, clr_done;
  logic        rd_pend_q, rd_owner_q, rd_a0_q, rd_wide_q, rd_err_q;
  logic [14:0] rd_idx_even_q, rd_idx_odd_q;
  logic [15:0] rd_word;

  assign m0_bus = '{we: m0_we, wide: m0_wide, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus = '{we: m1_we, wide: m1_wide, addr: m1_addr, wdata: m1_wdata};

`ifdef RAM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  logic [ADDRBITS-2:0] clr_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx_q <= '0;
    end else if (clearing) begin
      clr_idx_q <= clr_idx_q + 1'b1;
    end
  end

  assign clr_done = &clr_idx_q;
  assign busy     = clearing;
`else
  localparam state_t RESET_STATE = RUN;
  assign clr_done = 1'b1;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clearing = 1'b0;
    case (state_q)
      CLEAR: begin
        clearing = 1'b1;
        if (clr_done) state_d = RUN;
      end
      default: ;
    endcase
  end

  // No grants while reset is asserted or the clear walk owns the banks.
  assign arb_en = rst_n & ~clearing;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (arb_en),
    .req  ({m1_req, m0_req}),
    .gnt  (gnt)
  );

  always_comb begin
    sel       = gnt[1] ? m1_bus : m0_bus;
    map       = bank_map(sel.addr, sel.wide, sel.wdata);
    granted   = |gnt;
    range_err = (sel.addr < RAMBASE) || (sel.addr > RAM_TOP) ||
                (sel.wide && (sel.addr == RAM_TOP));

    write_addr_even = map.even_idx;
    write_addr_odd  = map.odd_idx;
    write_data_even = map.even_data;
    write_data_odd  = map.odd_data;
    write_en_even   = granted & sel.we & ~range_err & map.use_even;
    write_en_odd    = granted & sel.we & ~range_err & map.use_odd;
    read_addr_even  = granted ? map.even_idx : rd_idx_even_q;
    read_addr_odd   = granted ? map.odd_idx  : rd_idx_odd_q;
`ifdef RAM_CLEAR_EN
    if (clearing) begin
      write_addr_even = RAMBASE[15:1] + 15'(clr_idx_q);
      write_addr_odd  = RAMBASE[15:1] + 15'(clr_idx_q);
      write_data_even = 8'h00;
      write_data_odd  = 8'h00;
      write_en_even   = 1'b1;
      write_en_odd    = 1'b1;
    end
`endif
    write_en_even = write_en_even & rst_n;
    write_en_odd  = write_en_odd & rst_n;
  end

  assign m0_ack = gnt[0];
  assign m1_ack = gnt[1];
  assign m0_err = gnt[0] & range_err;
  assign m1_err = gnt[1] & range_err;

  // Capture who gets the read data and how to reassemble it from the banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q     <= 1'b0;
      rd_owner_q    <= 1'b0;
      rd_a0_q       <= 1'b0;
      rd_wide_q     <= 1'b0;
      rd_err_q      <= 1'b0;
      rd_idx_even_q <= '0;
      rd_idx_odd_q  <= '0;
    end else begin
      rd_pend_q <= granted & ~sel.we;
      if (granted) begin
        rd_owner_q    <= gnt[1];
        rd_a0_q       <= sel.addr[0];
        rd_wide_q     <= sel.wide;
        rd_err_q      <= range_err;
        rd_idx_even_q <= map.even_idx;
        rd_idx_odd_q  <= map.odd_idx;
      end
    end
  end

  always_comb begin
    if (rd_err_q) begin
      rd_word = 16'h0000;
    end else if (rd_wide_q) begin
      rd_word = rd_a0_q ? {read_data_odd, read_data_even} : {read_data_even, read_data_odd};
    end else begin
      rd_word = {8'h00, rd_a0_q ? read_data_odd : read_data_even};
    end
  end

  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q & rd_owner_q;
  assign m0_rdata  = m0_rvalid ? rd_word : 16'h0000;
  assign m1_rdata  = m1_rvalid ? rd_word : 16'h0000;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: bank RAM stand-in, byte-level reference model,
// directed cases and a randomized two-master run checked through scoreboards.
module tb_ram_port_arbiter;

  localparam int ADDRBITS   = 10;
  localparam int FIXED_PRIO = 0;
  localparam int SIZE       = 1 << ADDRBITS;
  localparam int RAMBASE    = 'h4000 - SIZE;
  localparam int HALF       = SIZE / 2;
  localparam int IDX_BASE   = RAMBASE / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_wide = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_wide = 1'b0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m0_rvalid, m1_ack, m1_err, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [14:0] read_addr_even, write_addr_even, read_addr_odd, write_addr_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic        write_en_even, write_en_odd;
  logic [7:0]  read_data_even = '0, read_data_odd = '0;
  logic        busy;

  ram_port_arbiter #(
    .ADDRBITS  (ADDRBITS),
    .FIXED_PRIO(FIXED_PRIO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wide(m0_wide), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wide(m1_wide), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .read_addr_even(read_addr_even), .write_addr_even(write_addr_even),
    .read_addr_odd(read_addr_odd), .write_addr_odd(write_addr_odd),
    .write_data_even(write_data_even), .write_data_odd(write_data_odd),
    .write_en_even(write_en_even), .write_en_odd(write_en_odd),
    .read_data_even(read_data_even), .read_data_odd(read_data_odd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous bank RAM stand-in, indexed relative to the RAM base word
  logic [7:0] even_mem [HALF];
  logic [7:0] odd_mem  [HALF];
  int ie_r, io_r, ie_w, io_w;

  always @(posedge clk) begin
    ie_r = int'(read_addr_even) - IDX_BASE;
    io_r = int'(read_addr_odd) - IDX_BASE;
    read_data_even <= (ie_r >= 0 && ie_r < HALF) ? even_mem[ie_r] : 8'h00;
    read_data_odd  <= (io_r >= 0 && io_r < HALF) ? odd_mem[io_r] : 8'h00;
    if (write_en_even) begin
      ie_w = int'(write_addr_even) - IDX_BASE;
      if (ie_w >= 0 && ie_w < HALF) even_mem[ie_w] = write_data_even;
    end
    if (write_en_odd) begin
      io_w = int'(write_addr_odd) - IDX_BASE;
      if (io_w >= 0 && io_w < HALF) odd_mem[io_w] = write_data_odd;
    end
  end

  // Reference model: flat big-endian byte memory plus last-winner bit
  logic [7:0] ref_mem [SIZE];
  bit         model_last = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {int port; bit err;} ack_exp_t;
  typedef struct {int port; logic [15:0] data;} rd_exp_t;
  ack_exp_t ack_q[$];
  rd_exp_t  rd_q[$];
  bit       mon_en = 1'b0;

  bit          pend_read = 1'b0;
  int          pend_port = 0;
  logic [15:0] pend_data = '0;

  function automatic bit model_err(input logic [15:0] a, input bit w);
    return (int'(a) < RAMBASE) || (int'(a) > 'h3fff) || (w && a == 16'h3fff);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input bit w);
    int i = int'(a) - RAMBASE;
    if (model_err(a, w)) return 16'h0000;
    if (w) return {ref_mem[i], ref_mem[i+1]};
    return {8'h00, ref_mem[i]};
  endfunction

  task automatic model_write(input logic [15:0] a, input bit w, input logic [15:0] d);
    int i = int'(a) - RAMBASE;
    if (model_err(a, w)) return;
    if (w) begin
      ref_mem[i]   = d[15:8];
      ref_mem[i+1] = d[7:0];
    end else begin
      ref_mem[i] = d[7:0];
    end
  endtask

  function automatic int pick_winner(input bit r0, input bit r1);
    if (r0 && r1) return (FIXED_PRIO != 0) ? 0 : (model_last ? 0 : 1);
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input bit we, input bit wide,
                               input logic [15:0] addr, input logic [15:0] wdata);
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_wide = wide; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_wide = wide; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic releaseReq(input int port);
    if (port == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  // Single-master access: drive, check the grant cycle, leave req high
  task automatic grantPhase(input int port, input bit we, input bit wide,
                            input logic [15:0] addr, input logic [15:0] wdata);
    bit err;
    @(posedge clk); #1;
    applyStimulus(port, we, wide, addr, wdata);
    @(negedge clk);
    err = model_err(addr, wide);
    checkOutput("ack", {m1_ack, m0_ack}, (port != 0) ? 2'b10 : 2'b01);
    checkOutput("err", (port != 0) ? m1_err : m0_err, err);
    if (err) checkOutput("write_en on err", {write_en_odd, write_en_even}, 2'b00);
    model_last = (port != 0);
    pend_read  = !we;
    pend_port  = port;
    pend_data  = model_read(addr, wide);
    if (we) model_write(addr, wide, wdata);
  endtask

  task automatic completePhase();
    @(posedge clk); #1;
    releaseReq(pend_port);
    @(negedge clk);
    if (pend_read) begin
      checkOutput("rvalid", {m1_rvalid, m0_rvalid}, (pend_port != 0) ? 2'b10 : 2'b01);
      checkOutput("rdata", (pend_port != 0) ? m1_rdata : m0_rdata, pend_data);
      checkOutput("rdata other", (pend_port != 0) ? m0_rdata : m1_rdata, 16'h0000);
    end else begin
      checkOutput("rvalid after write", {m1_rvalid, m0_rvalid}, 2'b00);
    end
    pend_read = 1'b0;
  endtask

  // Reset with a write held on m0 to make sure nothing leaks, then wait for busy
  task automatic do_reset();
    int cycles;
    int acks;
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 16'(RAMBASE), 16'hffff);
    releaseReq(1);
    #2;
    checkOutput("reset ack", {m1_ack, m0_ack}, 2'b00);
    checkOutput("reset err", {m1_err, m0_err}, 2'b00);
    checkOutput("reset write_en", {write_en_odd, write_en_even}, 2'b00);
    checkOutput("reset rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    checkOutput("reset m0_rdata", m0_rdata, 16'h0000);
    checkOutput("reset m1_rdata", m1_rdata, 16'h0000);
`ifdef RAM_CLEAR_EN
    checkOutput("reset busy", busy, 1'b1);
`else
    checkOutput("reset busy", busy, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    releaseReq(0);
`ifdef RAM_CLEAR_EN
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    applyStimulus(0, 1'b0, 1'b1, 16'h3e10, 16'h0000);
`endif
    model_last = 1'b1;
    pend_read  = 1'b0;
    rst_n = 1'b1;
    cycles = 0;
    acks = 0;
    while (busy && cycles < 2000) begin
      if (m0_ack) acks++;
      @(posedge clk); #1;
      cycles++;
    end
    releaseReq(0);
`ifdef RAM_CLEAR_EN
    checkOutput("busy cycles", cycles, 512);
    checkOutput("acks while busy", acks, 0);
`else
    checkOutput("busy cycles", cycles, 0);
`endif
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT shows ack or rvalid
  always @(negedge clk) begin
    if (mon_en) begin
      if (m0_ack || m1_ack) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected ack", {m1_ack, m0_ack}, 2'b00);
        end else begin
          ack_exp_t ae;
          ae = ack_q.pop_front();
          checkOutput("sb ack", {m1_ack, m0_ack}, (ae.port != 0) ? 2'b10 : 2'b01);
          checkOutput("sb err", m0_err | m1_err, ae.err);
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        end else begin
          rd_exp_t re;
          re = rd_q.pop_front();
          checkOutput("sb rvalid", {m1_rvalid, m0_rvalid}, (re.port != 0) ? 2'b10 : 2'b01);
          checkOutput("sb rdata", (re.port != 0) ? m1_rdata : m0_rdata, re.data);
          checkOutput("sb rdata other", (re.port != 0) ? m0_rdata : m1_rdata, 16'h0000);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          active [2];
    bit          done [2];
    bit          tx_we [2];
    bit          tx_wide [2];
    logic [15:0] tx_addr [2];
    logic [15:0] tx_wdata [2];
    int          w;
    int          r;
    ack_exp_t    ae;
    rd_exp_t     re;

    foreach (even_mem[i]) even_mem[i] = 8'h00;
    foreach (odd_mem[i]) odd_mem[i] = 8'h00;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    do_reset();

    grantPhase(0, 1'b1, 1'b1, 16'h3c00, 16'ha55a);
    checkOutput("wr addr even", write_addr_even, 15'h1e00);
    checkOutput("wr addr odd", write_addr_odd, 15'h1e00);
    checkOutput("wr data even", write_data_even, 8'ha5);
    checkOutput("wr data odd", write_data_odd, 8'h5a);
    checkOutput("wr en pair", {write_en_odd, write_en_even}, 2'b11);
    completePhase();
    grantPhase(0, 1'b0, 1'b1, 16'h3c00, 16'h0000);
    completePhase();

    grantPhase(1, 1'b1, 1'b1, 16'h3c01, 16'h1234);
    checkOutput("odd wr addr odd", write_addr_odd, 15'h1e00);
    checkOutput("odd wr data odd", write_data_odd, 8'h12);
    checkOutput("odd wr addr even", write_addr_even, 15'h1e01);
    checkOutput("odd wr data even", write_data_even, 8'h34);
    completePhase();
    grantPhase(0, 1'b0, 1'b0, 16'h3c01, 16'h0000);
    completePhase();
    grantPhase(0, 1'b0, 1'b0, 16'h3c02, 16'h0000);
    completePhase();

    grantPhase(0, 1'b1, 1'b0, 16'h3c05, 16'h0077);
    checkOutput("byte wr en", {write_en_odd, write_en_even}, 2'b10);
    checkOutput("byte wr addr", write_addr_odd, 15'h1e02);
    checkOutput("byte wr data", write_data_odd, 8'h77);
    completePhase();
    grantPhase(1, 1'b0, 1'b1, 16'h3c04, 16'h0000);
    completePhase();

    // Both masters requesting continuously
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b1, 16'h3c00, 16'h0000);
    applyStimulus(1, 1'b0, 1'b1, 16'h3c02, 16'h0000);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      w = pick_winner(1'b1, 1'b1);
      checkOutput("contended ack", {m1_ack, m0_ack}, (w != 0) ? 2'b10 : 2'b01);
      model_last = (w != 0);
      @(posedge clk); #1;
    end
    releaseReq(0);
    releaseReq(1);
    @(posedge clk); #1;

    grantPhase(0, 1'b1, 1'b0, 16'h3bff, 16'h00ee);
    completePhase();
    grantPhase(1, 1'b0, 1'b1, 16'h3fff, 16'h0000);
    completePhase();
    grantPhase(1, 1'b1, 1'b1, 16'h3fff, 16'hbeef);
    completePhase();
    grantPhase(0, 1'b0, 1'b0, 16'h4000, 16'h0000);
    completePhase();
    grantPhase(0, 1'b0, 1'b1, 16'h3ffe, 16'h0000);
    completePhase();
    grantPhase(0, 1'b0, 1'b1, 16'h3e10, 16'h0000);
    completePhase();

    // Reset lands between a read grant and its rvalid
    grantPhase(0, 1'b0, 1'b1, 16'h3c00, 16'h0000);
    do_reset();
    repeat (2) begin
      @(negedge clk);
      checkOutput("rvalid after reset", {m1_rvalid, m0_rvalid}, 2'b00);
    end

    // Randomized two-master traffic against the scoreboard
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      active[k] = 1'b0;
      done[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          active[k] = 1'b0;
          done[k] = 1'b0;
          releaseReq(k);
        end
        if (!active[k] && $urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 15);
          if (r == 0) tx_addr[k] = 16'h3bff;
          else if (r == 1) tx_addr[k] = 16'h3fff;
          else if (r == 2) tx_addr[k] = 16'($urandom);
          else if (r < 10) tx_addr[k] = 16'(RAMBASE + $urandom_range(0, 15));
          else tx_addr[k] = 16'(RAMBASE + $urandom_range(0, SIZE - 1));
          tx_we[k] = $urandom_range(0, 1) != 0;
          tx_wide[k] = $urandom_range(0, 1) != 0;
          tx_wdata[k] = 16'($urandom);
          applyStimulus(k, tx_we[k], tx_wide[k], tx_addr[k], tx_wdata[k]);
          active[k] = 1'b1;
        end
      end
      w = pick_winner(active[0], active[1]);
      if (w >= 0) begin
        ae.port = w;
        ae.err = model_err(tx_addr[w], tx_wide[w]);
        ack_q.push_back(ae);
        if (!tx_we[w]) begin
          re.port = w;
          re.data = model_read(tx_addr[w], tx_wide[w]);
          rd_q.push_back(re);
        end else begin
          model_write(tx_addr[w], tx_wide[w], tx_wdata[w]);
        end
        model_last = (w != 0);
        done[w] = 1'b1;
      end
    end
    @(posedge clk); #1;
    releaseReq(0);
    releaseReq(1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checkOutput("acks outstanding", ack_q.size(), 0);
    checkOutput("reads outstanding", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
